// File: rtl/issue_scheduler.sv
// Dual-lane in-order issue scheduler: scoreboard hazard checks and routing of
// up to two decoded instructions per cycle into four registered unit issue slots.
module issue_scheduler #(
    parameter int unsigned PAYLOAD_W = 32
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                flush_i,
    input  logic [1:0]                          slot_valid_i,
    input  logic [1:0][1:0]                     slot_unit_i,
    input  logic [1:0][4:0]                     slot_rd_i,
    input  logic [1:0][4:0]                     slot_rs1_i,
    input  logic [1:0][4:0]                     slot_rs2_i,
    input  logic [1:0]                          slot_rd_we_i,
    input  logic [1:0]                          slot_rs1_used_i,
    input  logic [1:0]                          slot_rs2_used_i,
    input  logic [1:0][PAYLOAD_W-1:0]           slot_payload_i,
    output logic [1:0]                          slot_ready_o,
    output logic [3:0]                          unit_valid_o,
    output logic [3:0][4:0]                     unit_rd_o,
    output logic [3:0]                          unit_rd_we_o,
    output logic [3:0][PAYLOAD_W-1:0]           unit_payload_o,
    input  logic [3:0]                          unit_ready_i,
    input  logic [1:0]                          wb_valid_i,
    input  logic [1:0][4:0]                     wb_rd_i,
    output logic [31:0]                         busy_o,
    output logic [31:0]                         stall_cnt_o
);

    localparam int unsigned NB_LANES = 2;
    localparam int unsigned NB_UNITS = 4;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned NB_REGS  = 32;
    localparam int unsigned CNT_W    = 32;

    logic [NB_UNITS-1:0]                 r_unit_valid;
    logic [NB_UNITS-1:0][REG_W-1:0]      r_unit_rd;
    logic [NB_UNITS-1:0]                 r_unit_rd_we;
    logic [NB_UNITS-1:0][PAYLOAD_W-1:0]  r_unit_payload;
    logic [NB_REGS-1:0]                  r_busy;
    logic [CNT_W-1:0]                    r_stall_cnt;

    logic [NB_REGS-1:0]                  w_wb_clear;
    logic [NB_REGS-1:0]                  w_busy_eff;
    logic [NB_REGS-1:0]                  w_busy_set;
    logic [NB_LANES-1:0]                 w_hazard;
    logic [NB_UNITS-1:0]                 w_unit_free;
    logic [NB_UNITS-1:0]                 w_load;
    logic [NB_UNITS-1:0]                 w_load_lane;
    logic                                w_pair_dep;
    logic [NB_LANES-1:0]                 w_acc;

    // Writebacks clear busy in the same cycle they are seen by hazard checks.
    always_comb begin
        w_wb_clear = '0;
        for (int j = 0; j < int'(NB_LANES); j++) begin
            if (wb_valid_i[j] && (wb_rd_i[j] != '0)) begin
                w_wb_clear[wb_rd_i[j]] = 1'b1;
            end
        end
        w_busy_eff = r_busy & ~w_wb_clear;
    end

    always_comb begin
        w_hazard    = '0;
        w_unit_free = '0;
        for (int k = 0; k < int'(NB_LANES); k++) begin
            w_hazard[k] = (slot_rs1_used_i[k] && w_busy_eff[slot_rs1_i[k]]) ||
                          (slot_rs2_used_i[k] && w_busy_eff[slot_rs2_i[k]]) ||
                          (slot_rd_we_i[k]    && w_busy_eff[slot_rd_i[k]]);
        end
        for (int u = 0; u < int'(NB_UNITS); u++) begin
            w_unit_free[u] = !r_unit_valid[u] || unit_ready_i[u];
        end
    end

    assign w_pair_dep = slot_rd_we_i[0] && (slot_rd_i[0] != '0) &&
                        ((slot_rs1_used_i[1] && (slot_rs1_i[1] == slot_rd_i[0])) ||
                         (slot_rs2_used_i[1] && (slot_rs2_i[1] == slot_rd_i[0])) ||
                         (slot_rd_we_i[1]    && (slot_rd_i[1]  == slot_rd_i[0])));

    assign w_acc[0] = reset_n && !flush_i && slot_valid_i[0] && !w_hazard[0] &&
                      w_unit_free[slot_unit_i[0]];
    assign w_acc[1] = w_acc[0] && slot_valid_i[1] && !w_hazard[1] &&
                      w_unit_free[slot_unit_i[1]] &&
                      (slot_unit_i[1] != slot_unit_i[0]) && !w_pair_dep;

    assign slot_ready_o = w_acc;

    // Route accepted lanes to their unit slots and collect new busy bits.
    always_comb begin
        w_load      = '0;
        w_load_lane = '0;
        w_busy_set  = '0;
        for (int k = 0; k < int'(NB_LANES); k++) begin
            if (w_acc[k]) begin
                w_load[slot_unit_i[k]]      = 1'b1;
                w_load_lane[slot_unit_i[k]] = 1'(k);
                if (slot_rd_we_i[k] && (slot_rd_i[k] != '0)) begin
                    w_busy_set[slot_rd_i[k]] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_unit_valid   <= '0;
            r_unit_rd      <= '0;
            r_unit_rd_we   <= '0;
            r_unit_payload <= '0;
            r_busy         <= '0;
            r_stall_cnt    <= '0;
        end else if (flush_i) begin
            r_unit_valid <= '0;
            r_busy       <= '0;
        end else begin
            r_busy <= w_busy_eff | w_busy_set;
            for (int u = 0; u < int'(NB_UNITS); u++) begin
                if (w_load[u]) begin
                    r_unit_valid[u]   <= 1'b1;
                    r_unit_rd[u]      <= slot_rd_i[w_load_lane[u]];
                    r_unit_rd_we[u]   <= slot_rd_we_i[w_load_lane[u]];
                    r_unit_payload[u] <= slot_payload_i[w_load_lane[u]];
                end else if (unit_ready_i[u]) begin
                    r_unit_valid[u] <= 1'b0;
                end
            end
            if (slot_valid_i[0] && !w_acc[0]) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign unit_valid_o   = r_unit_valid;
    assign unit_rd_o      = r_unit_rd;
    assign unit_rd_we_o   = r_unit_rd_we;
    assign unit_payload_o = r_unit_payload;
    assign busy_o         = r_busy;
    assign stall_cnt_o    = r_stall_cnt;

endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

Dual-lane in-order issue scheduler placed between the two-wide decode stage and the four execution units (ALU, SFT, BU, LSU). Each cycle it accepts up to two decoded instructions in program order, checks register hazards against a 32-entry scoreboard, and routes each accepted instruction into that unit's registered issue slot. Writebacks clear scoreboard bits. A stall counter feeds the scoreboard-full performance CSR.

## Interface
- PAYLOAD_W, 32: opaque per-instruction payload width (operation encoding, immediate, PC tag), passed through unchanged.
- NB_LANES, 2: issue lanes, equal to FRONTEND_WIDTH; fixed at 2.
- clk  in  1  clock, all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous pipeline flush.
- slot_valid_i  in  [2]  lane k holds a decoded instruction; lane 0 is older.
- slot_unit_i  in  [2][2]  target unit: 0 ALU, 1 SFT, 2 BU, 3 LSU.
- slot_rd_i, slot_rs1_i, slot_rs2_i  in  [2][5]  architectural register indices.
- slot_rd_we_i  in  [2]  instruction writes rd.
- slot_rs1_used_i, slot_rs2_used_i  in  [2]  source operand is read.
- slot_payload_i  in  [2][PAYLOAD_W]  pass-through payload.
- slot_ready_o  out  [2]  lane k accepted this cycle (combinational).
- unit_valid_o  out  [4]  issue slot of unit u holds an instruction.
- unit_rd_o  out  [4][5]; unit_rd_we_o  out  [4]; unit_payload_o  out  [4][PAYLOAD_W]  issue slot contents.
- unit_ready_i  in  [4]  unit u consumes its slot this cycle.
- wb_valid_i  in  [2]; wb_rd_i  in  [2][5]  writeback completions.
- busy_o  out  [32]  scoreboard; bit 0 is constant 0.
- stall_cnt_o  out  [32]  cycles lane 0 was valid but not accepted.

## Operation
- Scoreboard busy[31:1]. Effective view for hazard checks: busy_eff = busy & ~wb_clear, where wb_clear has bit r set when wb_valid_i[j] && wb_rd_i[j]==r for r != 0 (same-cycle writeback bypass).
- Hazard for a lane: the lane reads (used) rs1 or rs2, or writes (rd_we) rd, and that register is nonzero with busy_eff set. x0 never causes a hazard and is never marked busy.
- Unit u can accept when !unit_valid_o[u] || unit_ready_i[u].
- Lane 0 is accepted when slot_valid_i[0], there is no hazard, the unit can accept, and flush_i is low.
- Lane 1 is accepted only when all of the following hold:
  - lane 0 is accepted in the same cycle (in-order issue);
  - slot_valid_i[1], with no hazard and its unit able to accept;
  - slot_unit_i[1] != slot_unit_i[0];
  - no intra-pair RAW or WAW: if lane 0 writes nonzero rd, that rd must not match any used source or the written rd of lane 1.
- On accept: the unit slot loads rd, rd_we and payload, and its valid is set. If rd_we && rd != 0, busy[rd] is set.
- Unit slot drain: unit_ready_i[u] with no new load clears valid. Drain and load in the same cycle replace the contents, and valid stays 1.
- Scoreboard update priority: set beats clear for the same register in the same cycle. Both writeback ports are applied.
- Flush: all unit valids clear, all busy bits clear, no lane is accepted, and wb_valid_i is ignored that cycle.
- stall_cnt_o increments when slot_valid_i[0] && !slot_ready_o[0] && !flush_i, and wraps at 2^32.

## Timing
- Reset state: unit_valid_o=0, unit_rd_o=0, unit_rd_we_o=0, unit_payload_o=0, busy_o=0, stall_cnt_o=0. slot_ready_o is 0 while in reset.
- slot_ready_o is combinational from slot inputs, busy, unit valids, unit_ready_i, wb inputs and flush_i.
- Accept-to-issue latency is 1 cycle: an instruction accepted at edge N appears on unit_valid_o after edge N.
- The busy bit is visible on busy_o one cycle after accept. A dependent instruction stalls until its writeback cycle and can be accepted in that same writeback cycle.
- Throughput is 2 instructions per cycle to distinct units with no hazards.
- The frontend holds lane contents until slot_ready_o. Lane 1 may be re-presented as lane 0 in the next cycle.
- An asserted reset_n low mid-operation drops all in-flight state immediately.

## Test plan
- Reset: hold reset_n=0 and drive valid lanes. Required: slot_ready_o=00, busy_o=0. After release, stall_cnt_o=0.
- Dual issue: lane0 ALU rd=5, lane1 LSU rd=6, both accepted. Required: next cycle unit_valid_o[0] and unit_valid_o[3] are 1, busy_o=0x60.
- Intra-pair RAW: lane0 ALU rd=3, lane1 SFT rs1=3. Required: only lane 0 accepted. Next cycle lane 1 (as lane 0) stalls until wb_rd=3, and is accepted in that writeback cycle.
- Unit conflict and backpressure: both lanes BU, unit_ready_i[2]=0 with slot occupied. Required: both lanes stall and stall_cnt_o increments by 1 per cycle.
- x0 and set/clear collision: rd=0 writes never set busy. Accept rd=7 while wb_rd=7 in the same cycle. Required: busy[7]=1 afterwards.
- Flush with busy=0x0F0 and three unit slots valid. Required: next cycle busy_o=0, unit_valid_o=0, no lane accepted in the flush cycle.
